// File: rtl/mac_cfg_loader_pkg.sv
// ============================================================================
// mac_cfg_loader_pkg : shared widths, state encodings and cfg field offsets
// Revision: 1.0
// ============================================================================
`default_nettype none

package mac_cfg_loader_pkg;

   localparam int MAC_CONF_WIDTH = 4;
   localparam int MAC_MIN_WIDTH  = 8;
   localparam int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH;
   localparam int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH;
   localparam int CFG_IN_WIDTH   = 32;
   localparam int CFG_WIDTH      = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH;
   localparam int CFG_BEATS      = (CFG_WIDTH + CFG_IN_WIDTH - 1) / CFG_IN_WIDTH;
   localparam int BEAT_CNT_W     = $clog2(CFG_BEATS);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COMMIT = 2'd1;

   // Field map of the cfg bus: conf at the bottom, initial K above it.
   localparam int CONF_LSB = 0;

   function automatic int init_lsb(input int k);
      return MAC_ACC_WIDTH * k + MAC_CONF_WIDTH;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_cfg_shadow.sv
// ============================================================================
// mac_cfg_shadow : beat-indexed shadow register with beat counter and clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_cfg_shadow
   import mac_cfg_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [CFG_IN_WIDTH-1:0] wr_data,
   output logic [CFG_WIDTH-1:0]  shadow_nxt,
   output logic [BEAT_CNT_W-1:0] beat_cnt,
   output logic                  last_beat
);

   logic [CFG_WIDTH-1:0]  shadow_q;
   logic [CFG_WIDTH-1:0]  shadow_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q;
   logic [BEAT_CNT_W-1:0] beat_cnt_d;

   // The final beat is narrower than a full word; its upper bits are dropped.
   for (genvar i = 0; i < CFG_BEATS; i++) begin : g_beat
      localparam int LO = i * CFG_IN_WIDTH;
      localparam int W  = ((CFG_WIDTH - LO) < CFG_IN_WIDTH) ? (CFG_WIDTH - LO) : CFG_IN_WIDTH;
      assign shadow_d[LO +: W] = (wr_en && (beat_cnt_q == BEAT_CNT_W'(i)))
                               ? wr_data[W-1:0] : shadow_q[LO +: W];
   end

   assign last_beat  = (beat_cnt_q == BEAT_CNT_W'(CFG_BEATS - 1));
   assign shadow_nxt = shadow_d;
   assign beat_cnt   = beat_cnt_q;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (clr) begin
         beat_cnt_d = '0;
      end else if (wr_en) begin
         beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         shadow_q   <= shadow_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_cfg_loader.sv
// ============================================================================
// mac_cfg_loader : assembles cfg beats, commits the full cfg bus with a strobe
// Optional beat parity checking: define MAC_CFG_LOADER_PARITY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_cfg_loader
   import mac_cfg_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CFG_IN_WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   input  logic                    en_in,
`ifdef MAC_CFG_LOADER_PARITY_EN
   input  logic                    in_parity,
   output logic                    cfg_err,
`endif
   output logic [CFG_WIDTH-1:0]    cfg,
   output logic                    cset,
   output logic                    cluster_en,
   output logic                    busy
);

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [CFG_WIDTH-1:0]  cfg_q;
   logic [CFG_WIDTH-1:0]  cfg_d;
   logic [CFG_WIDTH-1:0]  shadow_nxt;
   logic [BEAT_CNT_W-1:0] beat_cnt;
   logic                  last_beat;
   logic                  accept;
   logic                  par_bad;
   logic                  beat_ok;
   logic                  shadow_clr;
   logic                  is_commit;

   assign accept = in_valid & in_ready;

`ifdef MAC_CFG_LOADER_PARITY_EN
   logic cfg_err_q;
   logic cfg_err_d;

   assign par_bad = accept & ((^in_data) != in_parity);

   always_comb begin
      cfg_err_d = cfg_err_q;
      if (flush) begin
         cfg_err_d = 1'b0;
      end else if (par_bad) begin
         cfg_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;
`else
   assign par_bad = 1'b0;
`endif

   // A bad-parity beat aborts the load exactly like a flush.
   assign beat_ok    = accept & ~par_bad;
   assign shadow_clr = (state_q == ST_IDLE) & (flush | par_bad);

   mac_cfg_shadow u_shadow (
      .clk        (clk),
      .rst        (rst),
      .clr        (shadow_clr),
      .wr_en      (beat_ok),
      .wr_data    (in_data),
      .shadow_nxt (shadow_nxt),
      .beat_cnt   (beat_cnt),
      .last_beat  (last_beat)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      case (state_q)
         ST_IDLE: begin
            if (beat_ok && last_beat) begin
               state_d = ST_COMMIT;
               cfg_d   = shadow_nxt;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      is_commit  = (state_q == ST_COMMIT);
      in_ready   = (state_q == ST_IDLE) && !flush;
      cset       = is_commit;
      cluster_en = en_in && !is_commit;
      busy       = is_commit || (beat_cnt != '0);
   end

   assign cfg = cfg_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_cfg_loader.sv
// ============================================================================
// tb_mac_cfg_loader : scoreboard bench with a beat-list reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_cfg_loader;
   import mac_cfg_loader_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [CFG_IN_WIDTH-1:0] in_data = '0;
   logic                    in_valid = 1'b0;
   logic                    flush = 1'b0;
   logic                    en_in = 1'b0;
   logic                    in_ready;
   logic [CFG_WIDTH-1:0]    cfg;
   logic                    cset;
   logic                    cluster_en;
   logic                    busy;
`ifdef MAC_CFG_LOADER_PARITY_EN
   logic                    in_parity = 1'b0;
   logic                    cfg_err;
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   mac_cfg_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
      .en_in      (en_in),
`ifdef MAC_CFG_LOADER_PARITY_EN
      .in_parity  (in_parity),
      .cfg_err    (cfg_err),
`endif
      .cfg        (cfg),
      .cset       (cset),
      .cluster_en (cluster_en),
      .busy       (busy)
   );

   typedef struct {
      int                   cyc;
      logic [CFG_WIDTH-1:0] cfg;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // Reference model: list of beats collected so far plus committed cfg.
   bit                   known    = 1'b0;
   bit                   m_commit = 1'b0;
   bit                   m_err    = 1'b0;
   int                   m_n      = 0;
   logic [31:0]          m_beats[CFG_BEATS];
   logic [CFG_WIDTH-1:0] m_cfg    = '0;

   task automatic chk(input string name, input logic [CFG_WIDTH-1:0] act, input logic [CFG_WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CFG_WIDTH-1:0] assemble();
      logic [CFG_BEATS*32-1:0] all;
      for (int k = 0; k < CFG_BEATS; k++) all[k*32 +: 32] = m_beats[k];
      return all[CFG_WIDTH-1:0];
   endfunction

   task automatic step(input bit r, input bit v, input logic [31:0] d, input bit fl,
                       input bit badpar, output bit acc);
      bit en;
      en = 1'($urandom_range(1));
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_data  = d;
      flush    = fl;
      en_in    = en;
`ifdef MAC_CFG_LOADER_PARITY_EN
      in_parity = (^d) ^ badpar;
`endif
      #1;
      if (known) begin
         chk("in_ready",   {131'd0, in_ready},   {131'd0, !m_commit && !fl});
         chk("cluster_en", {131'd0, cluster_en}, {131'd0, en && !m_commit});
         chk("busy",       {131'd0, busy},       {131'd0, m_commit || (m_n != 0)});
         chk("cfg_hold",   cfg, m_cfg);
`ifdef MAC_CFG_LOADER_PARITY_EN
         chk("cfg_err",    {131'd0, cfg_err},    {131'd0, m_err});
`endif
      end
      @(posedge clk);
      cyc++;
      acc = 1'b0;
      if (!r) begin
         known    = 1'b1;
         m_commit = 1'b0;
         m_n      = 0;
         m_cfg    = '0;
         m_err    = 1'b0;
      end else if (known) begin
         if (fl) m_err = 1'b0;
         if (m_commit) begin
            m_commit = 1'b0;
         end else if (fl) begin
            m_n = 0;
         end else if (v) begin
            acc = 1'b1;
            if (PAR_EN && badpar) begin
               m_err = 1'b1;
               m_n   = 0;
            end else begin
               m_beats[m_n] = d;
               m_n++;
               if (m_n == CFG_BEATS) begin
                  m_cfg    = assemble();
                  m_commit = 1'b1;
                  m_n      = 0;
                  sb.push_back('{cyc, m_cfg});
               end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0, acc);
   endtask

   // Holds each beat valid until it is accepted; optional gap before one beat.
   task automatic load(input logic [31:0] b[CFG_BEATS], input int gap_at, input int gap_len,
                       input int bad_idx);
      bit acc;
      for (int k = 0; k < CFG_BEATS; k++) begin
         if (k == gap_at) idle(gap_len);
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++)
            step(1'b1, 1'b1, b[k], 1'b0, (k == bad_idx), acc);
         if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: beat %0d not accepted within 20 cycles", k);
         end
      end
   endtask

   function automatic void rand_beats(output logic [31:0] b[CFG_BEATS], input logic [3:0] conf);
      for (int k = 0; k < CFG_BEATS; k++) b[k] = $urandom;
      b[0][3:0] = conf;
   endfunction

   // Monitor: pops an expectation whenever the DUT strobes cset.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL cset_missing: got no cset expected one at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
         end
         if (known && cset === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL cset_unexpected: got cset=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("cset_cycle", CFG_WIDTH'(cyc), CFG_WIDTH'(e.cyc));
               chk("cfg_commit", cfg, e.cfg);
            end
         end else if (known && cset !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL cset_value: got %b expected 0/1 (cycle %0d)", cset, cyc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected completion by 400000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]          nom[CFG_BEATS];
      logic [31:0]          b1[CFG_BEATS];
      logic [31:0]          b2[CFG_BEATS];
      logic [CFG_WIDTH-1:0] nom_cfg;
      bit                   acc;

      nom = '{32'h1111111A, 32'h22222221, 32'h33333332, 32'h44444443, 32'h00000004};
      nom_cfg = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 4'hA};

      step(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, '1, 1'b0, 1'b0, acc);
      idle(2);

      // Nominal load on consecutive cycles.
      load(nom, -1, 0, -1);
      idle(3);
      chk("nominal_cfg", cfg, nom_cfg);

      // Gap of 3 idle cycles between beats 2 and 3.
      rand_beats(b1, 4'h3);
      load(b1, 3, 3, -1);
      idle(2);
      load(nom, 3, 3, -1);
      idle(2);

      // Flush together with a valid beat after three beats.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, acc);
      step(1'b1, 1'b1, $urandom, 1'b1, 1'b0, acc);
      rand_beats(b1, 4'h5);
      load(b1, -1, 0, -1);
      idle(2);
      chk("flush_conf", CFG_WIDTH'(cfg[3:0]), CFG_WIDTH'(4'h5));

      // Reset after two beats, then a full load.
      for (int k = 0; k < 2; k++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, acc);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
      idle(2);
      rand_beats(b1, 4'hC);
      load(b1, -1, 0, -1);
      idle(2);

      // Back-to-back loads with valid held high.
      rand_beats(b1, 4'h1);
      rand_beats(b2, 4'h2);
      load(b1, -1, 0, -1);
      load(b2, -1, 0, -1);
      idle(3);

`ifdef MAC_CFG_LOADER_PARITY_EN
      rand_beats(b1, 4'h9);
      load(b1, -1, 0, 2);
      idle(1);
      chk("parity_err", {131'd0, cfg_err}, {131'd0, 1'b1});
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
      rand_beats(b1, 4'h6);
      load(b1, -1, 0, -1);
      idle(2);
      chk("parity_clean", {131'd0, cfg_err}, {131'd0, 1'b0});
`endif

      // Random traffic: valid, flush, reset and parity errors mixed.
      for (int k = 0; k < 800; k++) begin
         step(($urandom_range(99) != 0), ($urandom_range(9) < 7), $urandom,
              ($urandom_range(19) == 0), ($urandom_range(19) == 0), acc);
      end
      idle(4);

      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_drain: got %0d pending commits expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
